spi_fifo_uart_tx: RTL

- Downstream consumer of the SPI result FIFO in WETOP.
- Pops 40-bit words from the FIFO and sends each one to the host as one UART 8N1 frame: optional sync byte, then 5 payload bytes, MSB byte first.
- Replaces manual strobing of rd_en_fifo_spi_out with autonomous draining while enabled.

---
 rtl/spi_uart_pkg.sv | 38 +++
 rtl/uart_tx_byte.sv | 87 ++++++++
 rtl/spi_fifo_uart_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/spi_uart_pkg.sv
// Shared types and constants for the SPI-FIFO-to-UART drain path.
package spi_uart_pkg;

    // One enum covers both levels: the top walks Idle/Pop/Load/Data,
    // the byte serializer walks Idle/Start/Data/Stop.
    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StStop
    } tx_state_e;

    localparam int unsigned BYTES_PER_WORD    = 5;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned BIT_CNT_W         = 3;
    localparam int unsigned BAUD_CNT_W        = 16;
    localparam int unsigned BYTE_IDX_W        = 3;

    // Index 0 is the sync header, 1..5 walk the word from its top byte down.
    function automatic logic [7:0] frame_byte(input logic [8*BYTES_PER_WORD-1:0] word,
                                              input logic [BYTE_IDX_W-1:0]       idx,
                                              input logic [7:0]                  sync_byte);
        logic [7:0] b;
        b = sync_byte;
        case (idx)
            3'd1:    b = word[39:32];
            3'd2:    b = word[31:24];
            3'd3:    b = word[23:16];
            3'd4:    b = word[15:8];
            3'd5:    b = word[7:0];
            default: b = sync_byte;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as an 8N1 UART character. A start request arriving on
// the last stop-bit cycle chains the next character with no idle gap.
module uart_tx_byte
    import spi_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam logic [BAUD_CNT_W-1:0] BaudLast = BAUD_CNT_W'(CLK_DIV - 1);

    tx_state_e              state_q;
    logic [BAUD_CNT_W-1:0]  baud_q;
    logic [BIT_CNT_W-1:0]   bit_q;
    logic [7:0]             shift_q;
    logic                   tx_q;
    logic                   bit_end;

    assign bit_end = (baud_q == BaudLast);
    assign done    = (state_q == StStop) && bit_end;
    assign tx      = tx_q;

    // Character sequencer: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (start && (state_q == StIdle || done)) begin
            state_q <= StStart;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= data;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        baud_q <= baud_q + BAUD_CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (&bit_q) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + BIT_CNT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_CNT_W'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        baud_q  <= '0;
                    end else begin
                        baud_q <= baud_q + BAUD_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/spi_fifo_uart_tx.sv
// Drains the SPI result FIFO while enabled, sending each 40-bit word as one
// UART frame: optional sync byte followed by five payload bytes, MSB first.
module spi_fifo_uart_tx
    import spi_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned WORD_W    = 40,
    parameter bit          SYNC_EN   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_spi_out,
    output logic              rd_en_fifo_spi_out,
    output logic              uart_tx,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [BYTE_IDX_W-1:0] FirstIdx = SYNC_EN ? 3'd0 : 3'd1;
    localparam logic [BYTE_IDX_W-1:0] LastIdx  = BYTE_IDX_W'(BYTES_PER_WORD);

    // StData here means "frame bytes in flight"; the per-bit START/DATA/STOP
    // sequencing lives in uart_tx_byte.
    tx_state_e              state_q;
    logic [BYTE_IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0]      word_q;
    logic                   rd_en_q;
    logic                   busy_q;
    logic [15:0]            frame_cnt_q;

    logic                   byte_start;
    logic [7:0]             byte_data;
    logic                   byte_done;

    // First byte is launched from LOAD using the FIFO data directly, since the
    // word register is only written at the end of that cycle.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        if (state_q == StLoad) begin
            byte_start = 1'b1;
            byte_data  = frame_byte(fifo_spi_out, FirstIdx, SYNC_BYTE);
        end else if (state_q == StData && byte_done && idx_q != LastIdx) begin
            byte_start = 1'b1;
            byte_data  = frame_byte(word_q, idx_q + BYTE_IDX_W'(1), SYNC_BYTE);
        end
    end

    // Frame-level FSM: pop, load, step through bytes, count completed frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            word_q      <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tx_en && !fifo_empty) begin
                        state_q <= StPop;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StPop: begin
                    state_q <= StLoad;
                    rd_en_q <= 1'b0;
                end
                StLoad: begin
                    word_q  <= fifo_spi_out;
                    idx_q   <= FirstIdx;
                    state_q <= StData;
                end
                StData: begin
                    if (byte_done) begin
                        if (idx_q != LastIdx) begin
                            idx_q <= idx_q + BYTE_IDX_W'(1);
                        end else begin
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (uart_tx),
        .done  (byte_done)
    );

    assign rd_en_fifo_spi_out = rd_en_q;
    assign busy               = busy_q;
    assign frame_cnt          = frame_cnt_q;

endmodule
